// File: rtl/automat_pkg.sv
// automat_pkg: shared types and constants for the automat vending controller
// Contents: state_t FSM encoding, coin values (COIN1/COIN5/COIN10), default bottle price.
package automat_pkg;
    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;
    localparam int COIN1     = 1;
    localparam int COIN5     = 5;
    localparam int COIN10    = 10;
    localparam int PRICE_DEF = 3;
endpackage

// File: rtl/automat_coin_edge_detect.sv
// coin_edge_detect: rising-edge detector for one coin-acceptor line
// Ports: clk, reset (async active-low), d (coin level in), ev (high in the cycle d rises).
module coin_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic ev
);
    logic q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= 1'b0;
        else        q <= d;
    assign ev = d & ~q;
endmodule

// File: rtl/automat.sv
// automat: drink vending-machine controller (credit accumulation, dispense, change)
// Ports: clk, reset (async active-low); B1/B5/B10 coin levels in;
//        STICLA dispense pulse, R5/R1 change-coin pulses out (all registered).
// Build option: AUTOMAT_CHANGE_EN enables change return; without it excess credit is forfeited.
module automat
    import automat_pkg::*;
#(
    parameter int PRICE = PRICE_DEF,
    parameter int CW    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic B1,
    input  logic B5,
    input  logic B10,
    output logic R1,
    output logic R5,
    output logic STICLA
);
    state_t        state, state_n;
    logic [CW-1:0] credit, credit_n, sum, tot;
    logic          sticla_n, e1, e5, e10;
`ifdef AUTOMAT_CHANGE_EN
    logic [CW-1:0] change, change_n;
    logic          r1_n, r5_n;
`endif

    // Edge registers keep tracking during a sale so a held coin is never recounted.
    coin_edge_detect u_e1  (.clk(clk), .reset(reset), .d(B1),  .ev(e1));
    coin_edge_detect u_e5  (.clk(clk), .reset(reset), .d(B5),  .ev(e5));
    coin_edge_detect u_e10 (.clk(clk), .reset(reset), .d(B10), .ev(e10));

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state  <= IDLE;
            credit <= '0;
            STICLA <= 1'b0;
`ifdef AUTOMAT_CHANGE_EN
            change <= '0;
            R1     <= 1'b0;
            R5     <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            credit <= credit_n;
            STICLA <= sticla_n;
`ifdef AUTOMAT_CHANGE_EN
            change <= change_n;
            R1     <= r1_n;
            R5     <= r5_n;
`endif
        end

    always_comb begin
        sum      = (e1 ? CW'(COIN1) : '0) + (e5 ? CW'(COIN5) : '0) + (e10 ? CW'(COIN10) : '0);
        tot      = credit + sum;
        state_n  = state;
        credit_n = credit;
        sticla_n = 1'b0;
`ifdef AUTOMAT_CHANGE_EN
        change_n = change;
        r1_n     = 1'b0;
        r5_n     = 1'b0;
`endif
        case (state)
            IDLE:
                if (tot >= CW'(PRICE)) begin
                    state_n  = DISPENSE;
                    sticla_n = 1'b1;
                    credit_n = '0;
`ifdef AUTOMAT_CHANGE_EN
                    change_n = tot - CW'(PRICE);
`endif
                end else
                    credit_n = tot;
`ifdef AUTOMAT_CHANGE_EN
            // Largest coin first, one coin per cycle; coin events here are dropped.
            default:
                if (change >= CW'(COIN5)) begin
                    r5_n     = 1'b1;
                    change_n = change - CW'(COIN5);
                    state_n  = CHANGE;
                end else if (change != '0) begin
                    r1_n     = 1'b1;
                    change_n = change - CW'(COIN1);
                    state_n  = CHANGE;
                end else
                    state_n = IDLE;
`else
            default: state_n = IDLE;
`endif
        endcase
    end

`ifndef AUTOMAT_CHANGE_EN
    assign R1 = 1'b0;
    assign R5 = 1'b0;
`endif
endmodule

// File: tb/tb_automat.sv
module tb_automat;
    localparam int PRICE = 3;

    logic clk = 1'b0, reset = 1'b0, B1 = 1'b0, B5 = 1'b0, B10 = 1'b0;
    logic R1, R5, STICLA;

    automat #(.PRICE(PRICE), .CW(5)) dut (
        .clk(clk), .reset(reset), .B1(B1), .B5(B5), .B10(B10),
        .R1(R1), .R5(R5), .STICLA(STICLA)
    );

    always #5 clk = ~clk;

    typedef struct {int c; logic [2:0] v;} exp_t;
    exp_t q[$];
    exp_t mx;
    logic [2:0] mout;
    int cyc = 0, n_chk = 0, n_fail = 0;
    int credit = 0, free = 0;
    logic [2:0] prev = '0;
    bit in_rst = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: outputs as {STICLA,R5,R1}; every pulse must match the next expected entry.
    always @(negedge clk) begin
        mout = {STICLA, R5, R1};
        if (mout != 3'b000) begin
            if (q.size() == 0) check("unexpected_pulse", 32'(mout), 0);
            else begin
                mx = q.pop_front();
                check("pulse_value", 32'(mout), 32'(mx.v));
                check("pulse_cycle", cyc, mx.c);
            end
        end else if (q.size() != 0 && q[0].c <= cyc) begin
            mx = q.pop_front();
            check("missing_pulse", 32'(mout), 32'(mx.v));
        end
    end

    // Drive levels for the next edge and predict the sale from credit arithmetic.
    task automatic step(input logic b1, input logic b5, input logic b10);
        int e, ev, m;
`ifdef AUTOMAT_CHANGE_EN
        int ch;
`endif
        @(negedge clk);
        #2;
        B1 = b1; B5 = b5; B10 = b10;
        if (!in_rst) begin
            e  = cyc + 1;
            ev = ((b1 && !prev[0]) ? 1 : 0) + ((b5 && !prev[1]) ? 5 : 0) + ((b10 && !prev[2]) ? 10 : 0);
            prev = {b10, b5, b1};
            if (e >= free) begin
                credit += ev;
                if (credit >= PRICE) begin
                    m = 0;
                    q.push_back('{e, 3'b100});
`ifdef AUTOMAT_CHANGE_EN
                    ch = credit - PRICE;
                    while (ch >= 5) begin m++; q.push_back('{e + m, 3'b010}); ch -= 5; end
                    while (ch > 0)  begin m++; q.push_back('{e + m, 3'b001}); ch -= 1; end
`endif
                    credit = 0;
                    free   = e + m + 2;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        reset = 1'b0;
        in_rst = 1'b1;
        q.delete();
        credit = 0; prev = '0; free = 0;
        #1;
        check("reset_outputs", 32'({STICLA, R5, R1}), 0);
        for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge clk);
        #2;
        B1 = 0; B5 = 0; B10 = 0;
        check("reset_hold_outputs", 32'({STICLA, R5, R1}), 0);
        reset = 1'b1;
        in_rst = 1'b0;
    endtask

    initial begin
        do_reset(4);
        idle(3);
        step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(1, 0, 0);
        idle(4);
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
        idle(2);
        step(1, 0, 0); step(0, 0, 0); step(0, 1, 0);
        idle(8);
        step(0, 0, 1);
        idle(8);
        step(1, 1, 0); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
        idle(8);
        step(0, 0, 1); step(0, 0, 0);
        do_reset(2);
        idle(8);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(2);
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
        end
        idle(20);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
